// File: rtl/stream_byte_packer.sv
// stream_byte_packer
// Packs a stream of 8-bit bytes into BYTES_PER_WORD-byte words. Frame
// boundaries (last) are carried through. A frame whose length is not a
// multiple of the word size ends in a zero-padded word, flagged by out_partial.
// Two status counters are kept: frames emitted and padded words emitted.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   in_valid     input byte valid
//   in_ready     packer accepts a byte this cycle
//   in_data      input byte
//   in_last      final byte of a frame
//   out_valid    packed word valid
//   out_ready    downstream accepts the word
//   out_data     packed word (8*BYTES_PER_WORD bits)
//   out_last     word ends a frame
//   out_partial  word was zero-padded
//   frame_cnt    completed frames emitted (wraps)
//   partial_cnt  padded words emitted (saturates)
module stream_byte_packer #(
    parameter int BYTES_PER_WORD    = 4,
    parameter bit LSB_FIRST         = 1'b1,
    parameter bit REVERSE_BYTE_BITS = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic                        out_last,
    output logic                        out_partial,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 partial_cnt
);

    localparam int W    = 8 * BYTES_PER_WORD;
    localparam int IDXW = $clog2(BYTES_PER_WORD);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES_PER_WORD - 1);

    logic [W-1:0]    acc_reg;
    logic [IDXW-1:0] idx_reg;
    logic [7:0]      byte_in;
    logic [W-1:0]    merged;
    logic            word_completes;
    logic            out_fire;
    logic            accept;

    // Optional bit reversal compensates for the pad wiring order.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rev
        assign byte_in[gi] = REVERSE_BYTE_BITS ? in_data[7-gi] : in_data[gi];
    end

    // Each lane takes the incoming byte when the byte index selects it. The
    // lanes not yet written hold zero because the accumulator is cleared after
    // every word, so the same value serves as the zero-padded output word.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        localparam int K = LSB_FIRST ? gi : (BYTES_PER_WORD - 1 - gi);
        assign merged[8*gi +: 8] = (idx_reg == IDXW'(K)) ? byte_in : acc_reg[8*gi +: 8];
    end

    assign word_completes = (idx_reg == LAST_IDX) || in_last;
    assign out_fire       = out_valid && out_ready;
    // Stall only when a completing byte would find the output register full.
    // If the register is draining this cycle, it is reloaded without a bubble.
    assign in_ready       = !(out_valid && !out_ready) || !word_completes;
    assign accept         = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_reg     <= '0;
            idx_reg     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_partial <= 1'b0;
            frame_cnt   <= 16'd0;
            partial_cnt <= 16'd0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
                if (out_last) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
                if (out_partial && (partial_cnt != 16'hFFFF)) begin
                    partial_cnt <= partial_cnt + 16'd1;
                end
            end
            if (accept) begin
                if (word_completes) begin
                    out_valid   <= 1'b1;
                    out_data    <= merged;
                    out_last    <= in_last;
                    out_partial <= in_last && (idx_reg != LAST_IDX);
                    acc_reg     <= '0;
                    idx_reg     <= '0;
                end else begin
                    acc_reg <= merged;
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_byte_packer.sv
module tb_stream_byte_packer;

    logic        clk = 1'b0;
    logic        reset;

    // Instance A: default parameters.
    logic        a_in_valid, a_in_ready, a_in_last;
    logic [7:0]  a_in_data;
    logic        a_out_valid, a_out_ready, a_out_last, a_out_partial;
    logic [31:0] a_out_data;
    logic [15:0] a_frame_cnt, a_partial_cnt;

    // Instance B: MSB-first lane order with per-byte bit reversal.
    logic        b_in_valid, b_in_ready, b_in_last;
    logic [7:0]  b_in_data;
    logic        b_out_valid, b_out_ready, b_out_last, b_out_partial;
    logic [31:0] b_out_data;
    logic [15:0] b_frame_cnt, b_partial_cnt;

    logic        rand_mode, ready_force, rand_bit;

    int vectors     = 0;
    int miscompares = 0;
    int a_stalls    = 0;
    int exp_frames  = 0;
    int exp_partials = 0;

    // Entries: sent = {last, byte}; words = {last, partial, data}.
    logic [8:0]  sent[$];
    logic [33:0] exp_q[$];
    logic [33:0] a_got[$];
    logic [33:0] b_got[$];

    always #5 clk = ~clk;

    assign a_out_ready = rand_mode ? rand_bit : ready_force;

    always begin
        @(posedge clk);
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    stream_byte_packer dut_a (
        .clock(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_partial(a_out_partial),
        .frame_cnt(a_frame_cnt), .partial_cnt(a_partial_cnt)
    );

    stream_byte_packer #(.BYTES_PER_WORD(4), .LSB_FIRST(1'b0), .REVERSE_BYTE_BITS(1'b1)) dut_b (
        .clock(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_partial(b_out_partial),
        .frame_cnt(b_frame_cnt), .partial_cnt(b_partial_cnt)
    );

    // Output monitor: a word fires at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_out_valid && a_out_ready) a_got.push_back({a_out_last, a_out_partial, a_out_data});
            if (b_out_valid && b_out_ready) b_got.push_back({b_out_last, b_out_partial, b_out_data});
        end
    end

    // Reference: bytes fill a word in arrival order; a word closes when it
    // holds four bytes or when a byte carries last, with unused bytes zero.
    task automatic pack_model(input bit lsb, input bit rev);
        logic [31:0] word;
        logic [7:0]  v;
        int n, lane;
        exp_q.delete();
        word = '0;
        n = 0;
        foreach (sent[i]) begin
            for (int b = 0; b < 8; b++) v[b] = rev ? sent[i][7-b] : sent[i][b];
            lane = lsb ? n : 3 - n;
            word[8*lane +: 8] = v;
            n++;
            if (sent[i][8] || n == 4) begin
                exp_q.push_back({sent[i][8], sent[i][8] && (n != 4), word});
                if (sent[i][8]) exp_frames++;
                if (sent[i][8] && n != 4) exp_partials++;
                word = '0;
                n = 0;
            end
        end
    endtask

    task automatic a_send(input logic [7:0] d, input logic l);
        int n;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_last  = l;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 300) begin
            n++;
            a_stalls++;
            @(negedge clk);
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL a_send_timeout: in_ready stayed 0 for byte %02h, required 1", d);
        end
        sent.push_back({l, d});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d, input logic l);
        int n;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = l;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL b_send_timeout: in_ready stayed 0 for byte %02h, required 1", d);
        end
        sent.push_back({l, d});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for n collected words; the caller checks the count.
    task automatic wait_words(input int n, input bit use_b);
        int t;
        t = 0;
        while (((use_b ? b_got.size() : a_got.size()) < n) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        idle(3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0;
        b_out_ready = 1'b1;
        rand_mode = 1'b0;
        ready_force = 1'b1;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        vectors += 8;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b need 0", a_out_valid); end
        if (a_out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data: got %08h need 00000000", a_out_data); end
        if (a_out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %0b need 0", a_out_last); end
        if (a_out_partial !== 1'b0) begin miscompares++; $display("FAIL reset_out_partial: got %0b need 0", a_out_partial); end
        if (a_frame_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_frame_cnt: got %0d need 0", a_frame_cnt); end
        if (a_partial_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_partial_cnt: got %0d need 0", a_partial_cnt); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b need 1", a_in_ready); end
        if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_out_valid: got %0b need 0", b_out_valid); end
        $display("test_reset done");
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        sent.delete(); a_got.delete(); a_stalls = 0;
        for (int i = 1; i <= 8; i++) a_send(8'(i), i == 8);
        pack_model(1'b1, 1'b0);
        wait_words(exp_q.size(), 1'b0);
        vectors++;
        if (a_got.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d words need %0d", a_got.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= a_got.size() || a_got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL basic_word%0d: got %09h need %09h", i, (i < a_got.size()) ? a_got[i] : 34'h0, exp_q[i]);
            end else $display("basic word %0d = %09h", i, a_got[i]);
        end
        vectors += 4;
        if (a_got.size() < 2 || a_got[0] !== 34'h0_04030201 || a_got[1] !== 34'h2_08070605) begin
            miscompares++; $display("FAIL basic_literal: words did not equal 04030201 / 08070605(last)");
        end
        if (a_stalls != 0) begin miscompares++; $display("FAIL basic_in_ready: %0d stall cycles, need 0", a_stalls); end
        if (a_frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("FAIL basic_frame_cnt: got %0d need %0d", a_frame_cnt, exp_frames); end
        if (a_partial_cnt !== 16'(exp_partials)) begin miscompares++; $display("FAIL basic_partial_cnt: got %0d need %0d", a_partial_cnt, exp_partials); end
    endtask

    task automatic test_partial();
        sent.delete(); a_got.delete();
        for (int i = 0; i < 6; i++) a_send(8'hA0 + 8'(i), i == 5);
        pack_model(1'b1, 1'b0);
        wait_words(exp_q.size(), 1'b0);
        vectors++;
        if (a_got.size() != exp_q.size()) begin miscompares++; $display("FAIL partial_count: got %0d words need %0d", a_got.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= a_got.size() || a_got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL partial_word%0d: got %09h need %09h", i, (i < a_got.size()) ? a_got[i] : 34'h0, exp_q[i]);
            end else $display("partial word %0d = %09h", i, a_got[i]);
        end
        vectors += 3;
        if (a_got.size() < 2 || a_got[1] !== 34'h3_0000A5A4) begin miscompares++; $display("FAIL partial_literal: second word not 0000A5A4 with last+partial"); end
        if (a_frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("FAIL partial_frame_cnt: got %0d need %0d", a_frame_cnt, exp_frames); end
        if (a_partial_cnt !== 16'(exp_partials)) begin miscompares++; $display("FAIL partial_partial_cnt: got %0d need %0d", a_partial_cnt, exp_partials); end
    endtask

    task automatic test_backpressure();
        sent.delete(); a_got.delete();
        ready_force = 1'b0;
        for (int i = 0; i < 4; i++) a_send(8'h10 + 8'(i), 1'b0);
        a_stalls = 0;
        for (int i = 4; i < 7; i++) a_send(8'h10 + 8'(i), 1'b0);
        vectors++;
        if (a_stalls != 0) begin miscompares++; $display("FAIL bp_three_accepted: %0d stall cycles, need 0", a_stalls); end
        a_in_valid = 1'b1; a_in_data = 8'h17; a_in_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors += 3;
            if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %0b need 0", a_in_ready); end
            if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %0b need 1", a_out_valid); end
            if (a_out_data !== 32'h13121110) begin miscompares++; $display("FAIL bp_out_data_stable: got %08h need 13121110", a_out_data); end
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        a_send(8'h17, 1'b1);
        pack_model(1'b1, 1'b0);
        wait_words(exp_q.size(), 1'b0);
        vectors++;
        if (a_got.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d words need %0d", a_got.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= a_got.size() || a_got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %09h need %09h", i, (i < a_got.size()) ? a_got[i] : 34'h0, exp_q[i]);
            end else $display("backpressure word %0d = %09h", i, a_got[i]);
        end
        vectors++;
        if (a_got.size() < 2 || a_got[1] !== 34'h2_17161514) begin miscompares++; $display("FAIL bp_literal: second word not 17161514 with last"); end
    endtask

    task automatic test_random();
        int lasts;
        sent.delete(); a_got.delete();
        rand_mode = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            a_send(8'($urandom), i == 2047);
        end
        rand_mode = 1'b0;
        ready_force = 1'b1;
        pack_model(1'b1, 1'b0);
        wait_words(exp_q.size(), 1'b0);
        vectors++;
        if (a_got.size() != 512) begin miscompares++; $display("FAIL random_count: got %0d words need 512", a_got.size()); end
        lasts = 0;
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= a_got.size() || a_got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random_word%0d: got %09h need %09h", i, (i < a_got.size()) ? a_got[i] : 34'h0, exp_q[i]);
            end
        end
        foreach (a_got[i]) if (a_got[i][33]) lasts++;
        $display("random: %0d words collected, %0d carried last", a_got.size(), lasts);
        vectors += 3;
        if (lasts != 1 || a_got.size() < 512 || !a_got[511][33]) begin miscompares++; $display("FAIL random_last: %0d last flags, need exactly one on word 511", lasts); end
        if (a_frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("FAIL random_frame_cnt: got %0d need %0d", a_frame_cnt, exp_frames); end
        if (a_partial_cnt !== 16'(exp_partials)) begin miscompares++; $display("FAIL random_partial_cnt: got %0d need %0d", a_partial_cnt, exp_partials); end
    endtask

    task automatic test_reset_mid();
        sent.delete(); a_got.delete();
        ready_force = 1'b0;
        for (int i = 0; i < 6; i++) a_send(8'h21 + 8'(i), 1'b0);
        @(negedge clk);
        vectors++;
        if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pending: out_valid %0b need 1", a_out_valid); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %0b need 0", a_out_valid); end
        if (a_out_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_out_data: got %08h need 0", a_out_data); end
        if (a_frame_cnt !== 16'h0) begin miscompares++; $display("FAIL rstmid_frame_cnt: got %0d need 0", a_frame_cnt); end
        if (a_partial_cnt !== 16'h0) begin miscompares++; $display("FAIL rstmid_partial_cnt: got %0d need 0", a_partial_cnt); end
        exp_frames = 0; exp_partials = 0;
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        sent.delete(); a_got.delete();
        for (int i = 0; i < 4; i++) a_send(8'h31 + 8'(i), i == 3);
        pack_model(1'b1, 1'b0);
        wait_words(1, 1'b0);
        vectors += 3;
        if (a_got.size() != 1) begin miscompares++; $display("FAIL rstmid_count: got %0d words need 1", a_got.size()); end
        if (a_got.size() < 1 || a_got[0] !== 34'h2_34333231) begin
            miscompares++; $display("FAIL rstmid_word: got %09h need 234333231", (a_got.size() > 0) ? a_got[0] : 34'h0);
        end else $display("reset_mid word 0 = %09h", a_got[0]);
        if (a_frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("FAIL rstmid_frame_after: got %0d need %0d", a_frame_cnt, exp_frames); end
    endtask

    task automatic test_msb_reverse();
        logic [7:0] d0[4];
        int nb;
        d0[0] = 8'h01; d0[1] = 8'h02; d0[2] = 8'h03; d0[3] = 8'h80;
        sent.delete(); b_got.delete();
        exp_frames = 0; exp_partials = 0;
        for (int i = 0; i < 4; i++) b_send(d0[i], i == 3);
        // A few random frames, including short ones that pad.
        nb = 0;
        for (int i = 0; i < 120; i++) begin
            nb++;
            b_send(8'($urandom), (i == 119) || ($urandom_range(0, 4) == 0));
        end
        pack_model(1'b0, 1'b1);
        wait_words(exp_q.size(), 1'b1);
        vectors += 2;
        if (b_got.size() != exp_q.size()) begin miscompares++; $display("FAIL msbrev_count: got %0d words need %0d", b_got.size(), exp_q.size()); end
        if (b_got.size() < 1 || b_got[0] !== 34'h2_8040C001) begin
            miscompares++; $display("FAIL msbrev_first: got %09h need 28040C001", (b_got.size() > 0) ? b_got[0] : 34'h0);
        end else $display("msb_reverse word 0 = %09h", b_got[0]);
        foreach (exp_q[i]) begin
            vectors++;
            if (i >= b_got.size() || b_got[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL msbrev_word%0d: got %09h need %09h", i, (i < b_got.size()) ? b_got[i] : 34'h0, exp_q[i]);
            end
        end
        vectors += 2;
        if (b_frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("FAIL msbrev_frame_cnt: got %0d need %0d", b_frame_cnt, exp_frames); end
        if (b_partial_cnt !== 16'(exp_partials)) begin miscompares++; $display("FAIL msbrev_partial_cnt: got %0d need %0d", b_partial_cnt, exp_partials); end
        $display("msb_reverse: %0d random bytes, %0d words", nb, b_got.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_msb_reverse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
